// File: rtl/fir_serial_mac.sv
// Time-multiplexed signed FIR: one Baugh-Wooley multiplier shared by all taps, result TAPS cycles after acceptance.
// x_ready is high only in IDLE; FIR_SAT_EN selects clamping of the sum to OUT_W instead of wrapping.
module fir_serial_mac #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_data,
  output logic [OUT_W-1:0]        y_out,
  output logic                    y_valid,
  output logic                    y_sat
);
  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + IDX_W;
  localparam int EXT_W  = (OUT_W > ACC_W) ? OUT_W : ACC_W;

  typedef enum logic {IDLE, MAC} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0]       d_q [TAPS];
  logic [COEF_W-1:0]       c_q [TAPS];
  logic signed [ACC_W-1:0] acc_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    accept, mac_en, mac_last;

  logic [DATA_W-1:0]       mul_a;
  logic [COEF_W-1:0]       mul_b;
  logic [PROD_W-1:0]       prod;
  logic                    pp;
  logic signed [ACC_W-1:0] sum_next;
  logic signed [EXT_W-1:0] sum_ext;
  logic [OUT_W-1:0]        y_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (x_valid) state_d = MAC;
      MAC:  if (idx_q == IDX_W'(TAPS-1)) state_d = IDLE;
    endcase
  end

  always_comb begin
    x_ready  = (state_q == IDLE);
    accept   = x_ready & x_valid;
    mac_en   = (state_q == MAC);
    mac_last = mac_en && (idx_q == IDX_W'(TAPS-1));
  end

  assign mul_a = d_q[idx_q];
  assign mul_b = c_q[idx_q];

  // Sign-bit partial products are inverted and the correction constant added, so the sum is the exact signed product.
  always_comb begin
    prod = '0;
    pp   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < COEF_W; j++) begin
        pp = mul_a[i] & mul_b[j];
        if ((i == DATA_W-1) != (j == COEF_W-1)) pp = ~pp;
        prod = prod + (PROD_W'(pp) << (i + j));
      end
    end
    prod = prod + (PROD_W'(1) << (DATA_W-1)) + (PROD_W'(1) << (COEF_W-1))
                + (PROD_W'(1) << (PROD_W-1));
  end

  assign sum_next = acc_q + $signed({{IDX_W{prod[PROD_W-1]}}, prod});
  assign sum_ext  = EXT_W'(sum_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        d_q[k] <= '0;
        c_q[k] <= '0;
      end
      acc_q   <= '0;
      idx_q   <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (accept) begin
        d_q[0] <= x_in;
        for (int k = 1; k < TAPS; k++) d_q[k] <= d_q[k-1];
        acc_q <= '0;
        idx_q <= '0;
      end else if (mac_en) begin
        acc_q <= sum_next;
        idx_q <= idx_q + 1'b1;
        if (mac_last) begin
          y_out   <= y_next;
          y_valid <= 1'b1;
        end
      end
      // The MAC term read this cycle still sees the pre-write coefficient.
      if (coef_we && (int'(coef_addr) < TAPS)) c_q[coef_addr] <= coef_data;
    end
  end

`ifdef FIR_SAT_EN
  logic sat_next;

  always_comb begin
    sat_next = ~((&sum_ext[EXT_W-1:OUT_W-1]) | ~(|sum_ext[EXT_W-1:OUT_W-1]));
    y_next   = sum_ext[OUT_W-1:0];
    if (sat_next)
      y_next = sum_ext[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        y_sat <= 1'b0;
    else if (mac_last) y_sat <= sat_next;
    else               y_sat <= 1'b0;
  end
`else
  logic sum_unused;

  assign sum_unused = ^sum_ext[EXT_W-1:OUT_W-1];
  assign y_next     = sum_ext[OUT_W-1:0];
  assign y_sat      = 1'b0;
`endif

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac at default parameters; expectations follow FIR_SAT_EN.
module tb_fir_serial_mac;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        x_in;
  logic              x_valid;
  logic              x_ready;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [3:0]        coef_data;
  logic signed [6:0] y_out;
  logic              y_valid;
  logic              y_sat;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

`ifdef FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  fir_serial_mac dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y_out(y_out), .y_valid(y_valid), .y_sat(y_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [3:0] v);
    coef_we = 1'b1; coef_addr = a; coef_data = v;
    step();
    coef_we = 1'b0;
  endtask

  // Accept one sample and check the full TAPS-cycle latency and handshake.
  task automatic feed(input logic [3:0] x, input int exp_y, input logic exp_sat, input string tag);
    check({tag, "_rdy_before"}, x_ready, 1);
    x_in = x; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    check({tag, "_rdy_low"}, x_ready, 0);
    check({tag, "_vld_e0"}, y_valid, 0);
    repeat (3) step();
    check({tag, "_vld_e3"}, y_valid, 0);
    step();
    check({tag, "_vld"}, y_valid, 1);
    check({tag, "_y"}, y_out, exp_y);
    check({tag, "_sat"}, y_sat, exp_sat);
    check({tag, "_rdy_back"}, x_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; x_in = '0; x_valid = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    #1;
    check("rst_y", y_out, 0);
    check("rst_vld", y_valid, 0);
    check("rst_sat", y_sat, 0);
    check("rst_rdy", x_ready, 1);
    step(); step();
    rst_n = 1'b1;

    feed(4'd1, 0, 1'b0, "zero_coef");
    do_reset();

    // Impulse response
    wcoef(2'd0, 4'd1); wcoef(2'd1, 4'd2); wcoef(2'd2, 4'd3); wcoef(2'd3, 4'd4);
    feed(4'd1, 1, 1'b0, "imp0");
    feed(4'd0, 2, 1'b0, "imp1");
    feed(4'd0, 3, 1'b0, "imp2");
    feed(4'd0, 4, 1'b0, "imp3");
    feed(4'd0, 0, 1'b0, "imp4");

    // Reset while the MAC is running
    feed(4'd1, 1, 1'b0, "pre_abort");
    x_in = 4'd2; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_y", y_out, 0);
    check("abort_vld", y_valid, 0);
    check("abort_sat", y_sat, 0);
    check("abort_rdy", x_ready, 1);
    x_in = 4'd7; x_valid = 1'b1;
    step(); step();
    x_valid = 1'b0;
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      step();
      if (y_valid) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    feed(4'd1, 0, 1'b0, "post_abort");

    // Signed extremes: (-8)*(-8) accumulates 64,128,192,256
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(2'(k), 4'b1000);
    feed(4'b1000, SAT ? 63 : -64, SAT, "ext0");
    feed(4'b1000, SAT ? 63 :   0, SAT, "ext1");
    feed(4'b1000, SAT ? 63 : -64, SAT, "ext2");
    feed(4'b1000, SAT ? 63 :   0, SAT, "ext3");

    // Back-to-back with x_valid held high
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(2'(k), 4'd1);
    x_in = 4'd1; x_valid = 1'b1;
    for (int r = 0; r < 5; r++) begin
      step();
      check("b2b_rdy_e0", x_ready, 0);
      for (int c = 0; c < 3; c++) begin
        step();
        check("b2b_rdy_mac", x_ready, 0);
      end
      step();
      check("b2b_vld", y_valid, 1);
      check("b2b_y", y_out, (r < 3) ? r + 1 : 4);
      check("b2b_rdy_back", x_ready, 1);
    end
    x_valid = 1'b0;
    step();
    check("b2b_idle_vld", y_valid, 0);

    // Coefficient writes landing during MAC
    do_reset();
    for (int k = 0; k < 4; k++) wcoef(2'(k), 4'd1);
    x_in = 4'd2; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 4'd3;
    step();
    coef_addr = 2'd3;
    step();
    coef_we = 1'b0;
    step();
    check("cw_vld_e3", y_valid, 0);
    step();
    check("cw_vld", y_valid, 1);
    check("cw_y", y_out, 2);
    feed(4'd0, 2, 1'b0, "cw_next0");
    feed(4'd0, 2, 1'b0, "cw_next1");
    feed(4'd1, 9, 1'b0, "cw_new_coefs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_serial_mac.md
# fir_serial_mac

Parametrised, time-multiplexed signed FIR filter; successor to the fixed-width 4-bit-in / 7-bit-out filter. It takes TAPS programmable signed coefficients and a valid/ready input handshake. One Baugh-Wooley signed multiplier is reused across all taps, and the accumulated result is registered with a one-cycle valid pulse. It sits between the sample source and the downstream result consumer in the filter datapath.

## Interface
- DATA_W, 4: signed input sample width.
- COEF_W, 4: signed coefficient width.
- TAPS, 4: filter order +1, ≥2.
- OUT_W, 7: output width; internal ACC_W = DATA_W+COEF_W+$clog2(TAPS) (10 at defaults).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_in  in  DATA_W  signed sample.
- x_valid  in  1  sample present.
- x_ready  out  1  high only in IDLE.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  tap index; addr ≥ TAPS ignored.
- coef_data  in  COEF_W  signed coefficient.
- y_out  out  OUT_W  signed filtered output, registered.
- y_valid  out  1  one-cycle pulse, y_out new.
- y_sat  out  1  y_out was clamped (0 when saturation compiled out).

## Operation
- Reset (async, rst_n=0): state IDLE, delay line d[0..TAPS-1]=0, coefficients c[0..TAPS-1]=0, acc=0, idx=0, y_out=0, y_valid=0, y_sat=0; x_ready=1 (combinational from IDLE), but no acceptance while rst_n=0.
- States: IDLE, MAC.
- IDLE: on x_valid & x_ready at an edge: d[0]<=x_in, d[k]<=d[k-1], acc<=0, idx<=0, go MAC.
- MAC: each edge acc<=acc+sext(d[idx]*c[idx]), idx<=idx+1. On edge with idx==TAPS-1: y_out<=final sum mapped to OUT_W, y_valid<=1, go IDLE.
- y_valid cleared on the next edge unconditionally.
- Product: exact two's-complement DATA_W+COEF_W product via Baugh-Wooley structure, sign-extended to ACC_W; acc never overflows.
- Output mapping: see Configuration.
- Coefficient write: accepted any cycle incl. MAC; takes effect at that edge; a MAC term read in the same cycle uses the old value.
- x_valid while not IDLE: ignored, sample held by source (x_ready=0).
- Reset mid-MAC: operation aborted, no y_valid, all state cleared as above.

## Timing
- Acceptance edge E0 → MAC edges E1..E_TAPS → y_valid high in cycle after E_TAPS (latency TAPS cycles from acceptance).
- x_ready returns high in the same cycle y_valid is high; earliest next acceptance edge E_TAPS+1; throughput one sample per TAPS+1 cycles.
- y_out holds value until next result or reset.

## Configuration
- FIR_SAT_EN defined: final sum clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; y_sat=1 with y_valid when clamped, else 0.
- FIR_SAT_EN undefined: y_out = low OUT_W bits of sum (wrap); y_sat tied 0.

## Test plan
- Reset: rst_n=0 mid-stream → y_out=0, y_valid=0, y_sat=0, x_ready=1; subsequent impulse with no coef writes → y_out=0.
- Impulse: write c={1,2,3,4} to addr 0..3; feed x=1 then 0,0,0,0 → y_out sequence 1,2,3,4,0, each y_valid exactly 4 cycles after its acceptance edge.
- Signed extremes: all c=-8, feed x=-8 ×4 → sums 64,128,192,256; with FIR_SAT_EN y_out=63, y_sat=1 each; without, y_out=-64,0,-64,0, y_sat=0.
- Back-to-back: x_valid held high, x_in=1, c={1,1,1,1} → acceptance every 5 cycles, x_ready low 4 cycles each, y_out=1,2,3,4,4.
- Coef write in MAC: c={1,1,1,1}, accept x=2, write c[3]=3 on MAC edge E2 → y_out=2 (c[0] only, delay line else 0); next x=0 run → y_out reflects c[1]=1 term =2.
- Reset mid-MAC: assert rst_n=0 at E2 after acceptance → y_valid never pulses, next impulse behaves as fresh reset.
